// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and width helpers for the DDA clock-enable generator
package clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lock counter only has to reach LOCK_CYCLES-1.
  function automatic int lock_cnt_w(input int lock_cycles);
    return chw(lock_cycles);
  endfunction

endpackage

// File: rtl/clkgen_dda_ch.sv
// rtl/clkgen_dda_ch.sv - one fractional clock-enable channel (num register + DDA accumulator)
module clkgen_dda_ch
  import clkgen_pkg::*;
#(
  parameter int              ACC_W    = 16,
  parameter int              DEN      = 18,
  parameter logic [ACC_W-1:0] INIT_NUM = ACC_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wdata,
  output logic             ce
);

  localparam logic [ACC_W:0] DEN_X = (ACC_W+1)'(DEN);

  logic [ACC_W-1:0] num;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   n_clamp;
  logic [ACC_W:0]   sum;

  // Clamp the step to DEN so oversized ratios saturate at one strobe per cycle.
  always_comb begin
    n_clamp = {1'b0, num};
    if (n_clamp > DEN_X) begin
      n_clamp = DEN_X;
    end
    sum = {1'b0, acc} + n_clamp;
  end

  // Ratio register; kept across lock loss, only reset restores the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      num <= INIT_NUM;
    end else if (wr) begin
      num <= wdata;
    end
  end

  // Phase accumulator: wrap past DEN emits one strobe, idle or sync zeroes the phase.
  always_ff @(posedge clk) begin
    if (reset || !run || sync) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (sum >= DEN_X) begin
      acc <= ACC_W'(sum - DEN_X);
      ce  <= 1'b1;
    end else begin
      acc <= ACC_W'(sum);
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/clkgen_ce_dda.sv
// rtl/clkgen_ce_dda.sv - lock-gated multi-channel fractional clock-enable generator
module clkgen_ce_dda
  import clkgen_pkg::*;
#(
  parameter int                      NUM_CH      = 4,
  parameter int                      ACC_W       = 16,
  parameter int                      DEN         = 18,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_NUM = {NUM_CH{ACC_W'(1)}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pll_lock,
  input  logic                      cfg_we,
  input  logic [chw(NUM_CH)-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]          cfg_num,
  input  logic                      sync_req,
  output logic [NUM_CH-1:0]         ce,
  output logic                      rst_out,
  output logic                      running
);

  localparam int              CNT_W    = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic             lock_m;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic             run_en;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Lock filter FSM; rst_out/running are written alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      rst_out <= 1'b1;
      running <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lock_s) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= RUN;
            rst_out <= 1'b0;
            running <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= 1'b1;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          cnt     <= '0;
          rst_out <= 1'b1;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Qualifying with lock_s silences strobes in the same cycle the FSM leaves RUN.
  assign run_en = (state == RUN) && lock_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkgen_dda_ch #(
      .ACC_W    (ACC_W),
      .DEN      (DEN),
      .INIT_NUM (DEFAULT_NUM[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .run   (run_en),
      .sync  (sync_req),
      .wr    (cfg_we && (int'(cfg_ch) == i)),
      .wdata (cfg_num),
      .ce    (ce[i])
    );
  end

endmodule
